// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: in-order FPU issue queue with operand wakeup from the result broadcast bus
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   flush                     synchronous squash of all entries
//   in_valid/in_ready         dispatch handshake (in_ready = count != DEPTH)
//   in_ctrl/in_dd/in_imm      op select, destination tag, immediate
//   in_ds_*/in_dt_*           source operands: value, producer tag, present flag
//   cdb_valid/cdb_tag/cdb_val result broadcast bus
//   unit_busy                 any set bit blocks issue
//   iss_valid                 one-cycle pulse per issued op
//   ds_val/dt_val/dd/imm/ctrl registered issue payload
//   count                     occupied entries
//   stall_cnt                 cycles a ready head was blocked by unit_busy
//
// Optional feature: define FPU_IQ_STATS_EN to build the stall_cnt counter; otherwise it reads 0.
module fpu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_ctrl,
    input  logic [TAG_W-1:0]           in_dd,
    input  logic [15:0]                in_imm,
    input  logic [DATA_W-1:0]          in_ds_val,
    input  logic [TAG_W-1:0]           in_ds_tag,
    input  logic                       in_ds_rdy,
    input  logic [DATA_W-1:0]          in_dt_val,
    input  logic [TAG_W-1:0]           in_dt_tag,
    input  logic                       in_dt_rdy,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_val,
    input  logic [6:0]                 unit_busy,
    output logic                       iss_valid,
    output logic [DATA_W-1:0]          ds_val,
    output logic [DATA_W-1:0]          dt_val,
    output logic [TAG_W-1:0]           dd,
    output logic [15:0]                imm,
    output logic [3:0]                 ctrl,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]  v;
    logic [3:0]        q_ctrl  [DEPTH];
    logic [TAG_W-1:0]  q_dd    [DEPTH];
    logic [15:0]       q_imm   [DEPTH];
    logic [DATA_W-1:0] q_s_val [DEPTH];
    logic [TAG_W-1:0]  q_s_tag [DEPTH];
    logic [DEPTH-1:0]  q_s_rdy;
    logic [DATA_W-1:0] q_t_val [DEPTH];
    logic [TAG_W-1:0]  q_t_tag [DEPTH];
    logic [DEPTH-1:0]  q_t_rdy;
    logic [AW-1:0]     head, tail;
    logic              enq, head_rdy, iss, s_byp, t_byp;

    assign in_ready = count != CW'(DEPTH);
    assign enq      = in_valid && in_ready && !flush;
    // Readiness comes from registered state, so a wakeup takes effect one cycle later.
    assign head_rdy = v[head] && q_s_rdy[head] && q_t_rdy[head];
    assign iss      = head_rdy && unit_busy == '0;
    assign s_byp    = !in_ds_rdy && cdb_valid && cdb_tag == in_ds_tag;
    assign t_byp    = !in_dt_rdy && cdb_valid && cdb_tag == in_dt_tag;

    // Payload storage is qualified by v, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (v[i] && !q_s_rdy[i] && cdb_valid && cdb_tag == q_s_tag[i]) begin
                q_s_val[i] <= cdb_val;
                q_s_rdy[i] <= 1'b1;
            end
            if (v[i] && !q_t_rdy[i] && cdb_valid && cdb_tag == q_t_tag[i]) begin
                q_t_val[i] <= cdb_val;
                q_t_rdy[i] <= 1'b1;
            end
        end
        if (enq) begin
            q_ctrl[tail]  <= in_ctrl;
            q_dd[tail]    <= in_dd;
            q_imm[tail]   <= in_imm;
            q_s_tag[tail] <= in_ds_tag;
            q_t_tag[tail] <= in_dt_tag;
            q_s_val[tail] <= in_ds_rdy ? in_ds_val : cdb_val;
            q_t_val[tail] <= in_dt_rdy ? in_dt_val : cdb_val;
            q_s_rdy[tail] <= in_ds_rdy || s_byp;
            q_t_rdy[tail] <= in_dt_rdy || t_byp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v         <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            iss_valid <= 1'b0;
            ds_val    <= '0;
            dt_val    <= '0;
            dd        <= '0;
            imm       <= '0;
            ctrl      <= '0;
        end else if (flush) begin
            v         <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            iss_valid <= 1'b0;
        end else begin
            iss_valid <= iss;
            count     <= count + CW'(enq) - CW'(iss);
            // tail never equals a valid head here: enqueue requires a non-full queue.
            if (enq) begin
                v[tail] <= 1'b1;
                tail    <= tail + AW'(1);
            end
            if (iss) begin
                v[head] <= 1'b0;
                head    <= head + AW'(1);
                ds_val  <= q_s_val[head];
                dt_val  <= q_t_val[head];
                dd      <= q_dd[head];
                imm     <= q_imm[head];
                ctrl    <= q_ctrl[head];
            end
        end
    end

`ifdef FPU_IQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (head_rdy && unit_busy != '0 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule
